// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for the counter source and the downstream converter.
package gray_pkg;

    localparam int GRAY_W = 4;

    function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/gray_count_src_if.sv
// Control inputs plus the Gray code output handshake of gray_count_src.
import gray_pkg::*;

interface gray_count_src_if #(parameter int WIDTH = GRAY_W);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] g;
    logic             g_valid;
    logic             g_ready;
    logic             tc;

    modport master (input en, up, load, load_bin, g_ready, output g, g_valid, tc);
    modport slave  (output en, up, load, load_bin, g_ready, input g, g_valid, tc);
endinterface

// File: rtl/bin2gray_enc.sv
// Combinational binary-to-Gray encoder.
import gray_pkg::*;

module bin2gray_enc #(
    parameter int WIDTH = GRAY_W
) (
    input  logic [WIDTH-1:0] i_bin,
    output logic [WIDTH-1:0] o_g
);
    assign o_g = i_bin ^ (i_bin >> 1);
endmodule

// File: rtl/gray_count_src.sv
// Up/down Gray-code counter with a one-entry registered valid/ready output.
import gray_pkg::*;

module gray_count_src #(
    parameter int WIDTH = GRAY_W,
    parameter bit WRAP  = 1'b1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    gray_count_src_if.master    o_src
);
    localparam logic [WIDTH-1:0] ONES = '1;
    localparam logic [WIDTH-1:0] ZERO = '0;

    logic [WIDTH-1:0] r_bin, r_g;
    logic             r_vld, r_tc;

    logic             w_at_lim, w_adv, w_xfer, w_tc_d;
    logic [WIDTH-1:0] w_bin_step, w_bin_d, w_g_d;

    // A saturating counter parked at its limit issues nothing new.
    assign w_at_lim   = o_src.up ? (r_bin == ONES) : (r_bin == ZERO);
    assign w_adv      = o_src.en && (!r_vld || o_src.g_ready) && (WRAP || !w_at_lim);
    assign w_xfer     = r_vld && o_src.g_ready;
    assign w_bin_step = o_src.up ? r_bin + WIDTH'(1) : r_bin - WIDTH'(1);
    assign w_bin_d    = o_src.load ? o_src.load_bin : w_bin_step;

    always_comb begin
        w_tc_d = 1'b0;
        if (o_src.load)
            w_tc_d = (o_src.load_bin == ONES) || (o_src.load_bin == ZERO);
        else
            w_tc_d = o_src.up ? (w_bin_step == ONES) : (w_bin_step == ZERO);
    end

    bin2gray_enc #(.WIDTH(WIDTH)) u_enc (
        .i_bin (w_bin_d),
        .o_g   (w_g_d)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bin <= '0;
            r_g   <= '0;
            r_vld <= 1'b0;
            r_tc  <= 1'b0;
        end else if (o_src.load || w_adv) begin
            r_bin <= w_bin_d;
            r_g   <= w_g_d;
            r_vld <= 1'b1;
            r_tc  <= w_tc_d;
        end else if (w_xfer) begin
            r_vld <= 1'b0;
        end
    end

    assign o_src.g       = r_g;
    assign o_src.g_valid = r_vld;
    assign o_src.tc      = r_tc;
endmodule

// File: tb/tb_gray_count_src.sv
// Directed bench for gray_count_src: one wrapping and one saturating instance.
module tb_gray_count_src;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gray_count_src_if #(.WIDTH(4)) b1 ();
    gray_count_src_if #(.WIDTH(4)) b0 ();

    gray_count_src #(.WIDTH(4), .WRAP(1'b1)) u_wrap (.i_clk(clk), .i_rst(rst), .o_src(b1));
    gray_count_src #(.WIDTH(4), .WRAP(1'b0)) u_sat  (.i_clk(clk), .i_rst(rst), .o_src(b0));

    int total = 0;
    int bad   = 0;

    logic [3:0] m_bin [2];
    logic       m_vld [2];
    logic [3:0] m_g   [2];
    logic       m_tc  [2];
    logic [4:0] sb [$];
    logic [3:0] prev_g;
    logic [3:0] held_g;

    function automatic logic [3:0] gr(input logic [3:0] b);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (i == 3) ? b[3] : (b[i] ^ b[i+1]);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] obs_g(input int d);
        return d ? b1.g : b0.g;
    endfunction
    function automatic logic obs_v(input int d);
        return d ? b1.g_valid : b0.g_valid;
    endfunction
    function automatic logic obs_tc(input int d);
        return d ? b1.tc : b0.tc;
    endfunction

    task automatic idle_all();
        b1.en = 0; b1.up = 0; b1.load = 0; b1.load_bin = 0; b1.g_ready = 0;
        b0.en = 0; b0.up = 0; b0.load = 0; b0.load_bin = 0; b0.g_ready = 0;
    endtask

    task automatic do_reset();
        idle_all();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m_bin[d] = 0; m_vld[d] = 0; m_g[d] = 0; m_tc[d] = 0;
            chk($sformatf("rst_g%0d", d), 8'(obs_g(d)), 8'h0);
            chk($sformatf("rst_v%0d", d), 8'(obs_v(d)), 8'h0);
            chk($sformatf("rst_tc%0d", d), 8'(obs_tc(d)), 8'h0);
        end
    endtask

    // One clock on instance d (1 = wrapping, 0 = saturating); the other idles.
    task automatic cyc(input int d, input logic en, input logic up, input logic ld,
                       input logic [3:0] lb, input logic rdy, input string tag);
        logic lim, adv, nw;
        logic [3:0] nb;
        logic [4:0] e;
        idle_all();
        if (d) begin b1.en = en; b1.up = up; b1.load = ld; b1.load_bin = lb; b1.g_ready = rdy; end
        else   begin b0.en = en; b0.up = up; b0.load = ld; b0.load_bin = lb; b0.g_ready = rdy; end
        lim = up ? (m_bin[d] == 4'hF) : (m_bin[d] == 4'h0);
        adv = en && (!m_vld[d] || rdy) && (d == 1 || !lim);
        nw  = 1'b0;
        if (ld) begin
            m_bin[d] = lb; nw = 1'b1;
            sb.push_back({gr(lb), (lb == 4'hF) || (lb == 4'h0)});
        end else if (adv) begin
            nb = up ? m_bin[d] + 4'd1 : m_bin[d] - 4'd1;
            m_bin[d] = nb; nw = 1'b1;
            sb.push_back({gr(nb), up ? (nb == 4'hF) : (nb == 4'h0)});
        end else if (m_vld[d] && rdy) begin
            m_vld[d] = 1'b0;
        end
        if (nw) m_vld[d] = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_v"}, 8'(obs_v(d)), 8'(m_vld[d]));
        if (nw) begin
            if (sb.size() == 0) begin
                chk({tag, "_sb_empty"}, 8'h1, 8'h0);
            end else begin
                e = sb.pop_front();
                m_g[d] = e[4:1]; m_tc[d] = e[0];
            end
        end
        chk({tag, "_g"}, 8'(obs_g(d)), 8'(m_g[d]));
        chk({tag, "_tc"}, 8'(obs_tc(d)), 8'(m_tc[d]));
    endtask

    initial begin
        idle_all();
        rst = 1'b1;
        do_reset();

        // Count up through a full wrap; each step flips exactly one bit.
        prev_g = 4'h0;
        for (int i = 0; i < 16; i++) begin
            cyc(1, 1, 1, 0, 0, 1, $sformatf("up%0d", i));
            chk($sformatf("onebit%0d", i), 8'($countones(prev_g ^ b1.g)), 8'd1);
            prev_g = b1.g;
        end
        chk("wrap_to_zero", 8'(b1.g), 8'h0);

        // Load zero then step down: wraps to 15.
        cyc(1, 0, 0, 1, 4'd0, 1, "ld0");
        chk("ld0_tc", 8'(b1.tc), 8'h1);
        cyc(1, 1, 0, 0, 0, 1, "dn15");
        chk("dn15_g", 8'(b1.g), 8'h8);

        // Stall for three cycles, then release: exactly one new code.
        held_g = b1.g;
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 0, 0, 0, 0, $sformatf("stall%0d", i));
            chk($sformatf("stall_hold%0d", i), 8'(b1.g), 8'(held_g));
        end
        cyc(1, 1, 0, 0, 0, 1, "release");
        chk("release_g", 8'(b1.g), 8'h9);
        cyc(1, 0, 0, 0, 0, 1, "drain");
        chk("drain_g_hold", 8'(b1.g), 8'h9);

        // Load wins over a stalled output with en asserted.
        cyc(1, 1, 1, 0, 0, 0, "fill");
        cyc(1, 1, 1, 1, 4'd9, 0, "ld9");
        chk("ld9_g", 8'(b1.g), 8'hD);

        // Saturating instance at the top limit.
        cyc(0, 0, 1, 1, 4'd14, 1, "s_ld14");
        cyc(0, 1, 1, 0, 0, 1, "s_up15");
        chk("s_up15_g", 8'(b0.g), 8'h8);
        cyc(0, 1, 1, 0, 0, 1, "s_sat1");
        cyc(0, 1, 1, 0, 0, 1, "s_sat2");
        cyc(0, 1, 0, 0, 0, 1, "s_dn14");
        chk("s_dn14_g", 8'(b0.g), 8'h9);
        // And at the bottom limit.
        cyc(0, 0, 0, 1, 4'd0, 1, "s_ld0");
        cyc(0, 1, 0, 0, 0, 1, "s_sat0");

        // Reset while the wrapping instance is stalled holding 1101.
        chk("pre_rst_v", 8'(b1.g_valid), 8'h1);
        do_reset();

        chk("sb_drained", 8'(sb.size()), 8'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
